// File: rtl/rgb_mixer_multi_if.sv
// Encoder inputs and PWM/readback outputs of the multi-channel RGB mixer.
// The design sits on the slave side; the driver of the encoders is the master.
interface rgb_mixer_multi_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8
);
    logic [NUM_CH-1:0]       enc_a;
    logic [NUM_CH-1:0]       enc_b;
    logic [NUM_CH-1:0]       pwm_out;
    logic [NUM_CH*WIDTH-1:0] value_o;
    logic                    period_start;

    modport master (output enc_a, enc_b, input pwm_out, value_o, period_start);
    modport slave  (input enc_a, enc_b, output pwm_out, value_o, period_start);
endinterface

// File: rtl/rgb_mixer_multi.sv
// NUM_CH rotary-encoder duty registers feeding NUM_CH PWM outputs off one shared counter.
// Each lane debounces its encoder on a shared prescaler tick; duty changes land at period boundaries.
module rgb_mixer_lane #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int SATURATE   = 1,
    parameter int INIT_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             cnt_max,
    input  logic [WIDTH-1:0] cnt,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             pwm,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] MAX_W  = '1;

    logic [1:0]       sync_a, sync_b;
    logic [2:0]       hist_a, hist_b;
    logic             deb_a, deb_b, prev_a, rise;
    logic [WIDTH-1:0] shadow, up_v, dn_v;
    logic [WIDTH:0]   sum, diff;

    // The extra top bit of sum/diff is the overflow/borrow flag used for clamping.
    assign sum  = {1'b0, value} + STEP_W;
    assign diff = {1'b0, value} - STEP_W;
    assign up_v = (SATURATE != 0 && sum[WIDTH])  ? MAX_W : sum[WIDTH-1:0];
    assign dn_v = (SATURATE != 0 && diff[WIDTH]) ? '0    : diff[WIDTH-1:0];
    assign rise = deb_a & ~prev_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= '0;
            hist_b <= '0;
            deb_a  <= 1'b0;
            deb_b  <= 1'b0;
            prev_a <= 1'b0;
            value  <= INIT_W;
            shadow <= INIT_W;
            pwm    <= 1'b0;
        end else begin
            sync_a <= {sync_a[0], enc_a};
            sync_b <= {sync_b[0], enc_b};
            if (tick) begin
                hist_a <= {hist_a[1:0], sync_a[1]};
                hist_b <= {hist_b[1:0], sync_b[1]};
            end
            // Debounced level only moves on a full run of agreeing samples.
            if (hist_a == 3'b111)      deb_a <= 1'b1;
            else if (hist_a == 3'b000) deb_a <= 1'b0;
            if (hist_b == 3'b111)      deb_b <= 1'b1;
            else if (hist_b == 3'b000) deb_b <= 1'b0;
            prev_a <= deb_a;
            if (rise) value <= deb_b ? dn_v : up_v;
            if (cnt_max) shadow <= value;
            pwm <= (cnt < shadow);
        end
    end
endmodule

module rgb_mixer_multi #(
    parameter int NUM_CH     = 3,
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int SATURATE   = 1,
    parameter int DEB_DIV    = 16,
    parameter int INIT_VALUE = 0
) (
    input logic               clk,
    input logic               reset_n,
    rgb_mixer_multi_if.slave  bus
);
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    logic [DW-1:0]                 deb_cnt;
    logic                          tick, cnt_max, period_start;
    logic [WIDTH-1:0]              cnt;
    logic [NUM_CH-1:0][WIDTH-1:0]  vals;
    logic [NUM_CH-1:0]             pwm;

    assign tick    = (deb_cnt == DW'(DEB_DIV - 1));
    assign cnt_max = &cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt      <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            deb_cnt      <= tick ? '0 : deb_cnt + DW'(1);
            cnt          <= cnt + WIDTH'(1);
            period_start <= cnt_max;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        rgb_mixer_lane #(
            .WIDTH(WIDTH), .STEP(STEP), .SATURATE(SATURATE), .INIT_VALUE(INIT_VALUE)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .cnt_max (cnt_max),
            .cnt     (cnt),
            .enc_a   (bus.enc_a[i]),
            .enc_b   (bus.enc_b[i]),
            .pwm     (pwm[i]),
            .value   (vals[i])
        );
    end

    assign bus.value_o      = vals;
    assign bus.pwm_out      = pwm;
    assign bus.period_start = period_start;
endmodule

// File: tb/tb_rgb_mixer_multi.sv
// Four mixers with different STEP/SATURATE/INIT share one encoder stimulus and are
// compared against a detent-level model of the duty values and per-period high counts.
module tb_rgb_mixer_multi;
    localparam int NC   = 3;
    localparam int W    = 8;
    localparam int DD   = 16;
    localparam int ND   = 4;
    localparam int HOLD = 5 * DD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] enc_a = '0;
    logic [NC-1:0] enc_b = '0;

    int checks = 0;
    int failures = 0;
    int mv [ND][NC];
    int hi [ND][NC];

    always #5 clk = ~clk;

    rgb_mixer_multi_if #(.NUM_CH(NC), .WIDTH(W)) if0 ();
    rgb_mixer_multi_if #(.NUM_CH(NC), .WIDTH(W)) if1 ();
    rgb_mixer_multi_if #(.NUM_CH(NC), .WIDTH(W)) if2 ();
    rgb_mixer_multi_if #(.NUM_CH(NC), .WIDTH(W)) if3 ();

    assign if0.enc_a = enc_a; assign if0.enc_b = enc_b;
    assign if1.enc_a = enc_a; assign if1.enc_b = enc_b;
    assign if2.enc_a = enc_a; assign if2.enc_b = enc_b;
    assign if3.enc_a = enc_a; assign if3.enc_b = enc_b;

    rgb_mixer_multi #(.NUM_CH(NC), .WIDTH(W), .STEP(1), .SATURATE(1), .DEB_DIV(DD), .INIT_VALUE(0))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    rgb_mixer_multi #(.NUM_CH(NC), .WIDTH(W), .STEP(4), .SATURATE(1), .DEB_DIV(DD), .INIT_VALUE(254))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    rgb_mixer_multi #(.NUM_CH(NC), .WIDTH(W), .STEP(1), .SATURATE(0), .DEB_DIV(DD), .INIT_VALUE(0))
        u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    rgb_mixer_multi #(.NUM_CH(NC), .WIDTH(W), .STEP(190), .SATURATE(1), .DEB_DIV(DD), .INIT_VALUE(10))
        u_dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    logic [ND-1:0][NC-1:0]   pwm_all;
    logic [ND-1:0][NC*W-1:0] val_all;
    logic [ND-1:0]           ps_all;

    assign pwm_all = {if3.pwm_out, if2.pwm_out, if1.pwm_out, if0.pwm_out};
    assign val_all = {if3.value_o, if2.value_o, if1.value_o, if0.value_o};
    assign ps_all  = {if3.period_start, if2.period_start, if1.period_start, if0.period_start};

    function automatic int init_of(int d);
        case (d) 1: return 254; 3: return 10; default: return 0; endcase
    endfunction
    function automatic int step_of(int d);
        case (d) 1: return 4; 3: return 190; default: return 1; endcase
    endfunction
    function automatic bit sat_of(int d);
        return (d != 2);
    endfunction

    // One detent of the encoder moves the duty by STEP, clamped or wrapped.
    function automatic int model_step(int v, bit up, int d);
        int r, mx;
        mx = (1 << W) - 1;
        r  = up ? v + step_of(d) : v - step_of(d);
        if (sat_of(d)) begin
            if (r > mx) r = mx;
            if (r < 0)  r = 0;
        end else begin
            r = r & mx;
        end
        return r;
    endfunction

    function automatic int val_of(int d, int c);
        return int'(val_all[d][c*W +: W]);
    endfunction

    task automatic tick_n(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < NC; c++) mv[d][c] = init_of(d);
    endtask

    task automatic check_vals(string tag);
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (val_of(d, c) !== mv[d][c]) begin
                    failures++;
                    $display("FAIL %s value d%0d ch%0d got %0d exp %0d", tag, d, c, val_of(d, c), mv[d][c]);
                end
            end
    endtask

    task automatic detent(logic [NC-1:0] up_m, logic [NC-1:0] dn_m);
        logic [NC-1:0] act;
        act   = up_m | dn_m;
        enc_b = dn_m;
        tick_n(HOLD);
        enc_a = act;
        tick_n(HOLD);
        enc_a = '0;
        tick_n(HOLD);
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < NC; c++)
                if (act[c]) mv[d][c] = model_step(mv[d][c], !dn_m[c], d);
    endtask

    task automatic wait_ps(string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ps_all[0]) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s period_start timeout got none exp pulse within 300 cycles", tag);
        end
    endtask

    // Counts PWM high cycles over one full period, starting at the period_start cycle.
    task automatic check_pwm(string tag);
        bit ok;
        wait_ps(tag, ok);
        if (ok) begin
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < NC; c++) hi[d][c] = 0;
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge clk);
                for (int d = 0; d < ND; d++)
                    for (int c = 0; c < NC; c++) hi[d][c] += int'(pwm_all[d][c]);
            end
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < NC; c++) begin
                    checks++;
                    if (hi[d][c] !== mv[d][c]) begin
                        failures++;
                        $display("FAIL %s pwm_high d%0d ch%0d got %0d exp %0d", tag, d, c, hi[d][c], mv[d][c]);
                    end
                end
        end
    endtask

    task automatic test_reset();
        int n_hi, n_ps, first, prev, gap;
        reset_n = 1'b0;
        model_reset();
        #23;
        reset_n = 1'b1;
        #1;
        check_vals("reset");
        checks++;
        if (pwm_all !== '0 || ps_all !== '0) begin
            failures++;
            $display("FAIL reset outputs got pwm=%h ps=%b exp 0", pwm_all, ps_all);
        end
        n_hi = 0; n_ps = 0; first = -1; prev = -1; gap = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_hi += int'(pwm_all[0] != '0) + int'(pwm_all[2] != '0);
            if (ps_all[0]) begin
                if (first < 0) first = i;
                else if (gap == 0) gap = i - prev;
                prev = i;
                n_ps++;
            end
        end
        checks++;
        if (n_hi !== 0) begin
            failures++;
            $display("FAIL reset pwm_idle got %0d high cycles exp 0", n_hi);
        end
        checks++;
        if (first !== 255 || gap !== 256 || n_ps !== 2) begin
            failures++;
            $display("FAIL reset period_start got first=%0d gap=%0d n=%0d exp 255/256/2", first, gap, n_ps);
        end
    endtask

    task automatic test_mid_period();
        int old_v [ND];
        int hi_old [ND];
        int hi_new [ND];
        int chg;
        bit ok;
        enc_b = '0;
        tick_n(HOLD);
        for (int d = 0; d < ND; d++) begin
            old_v[d] = mv[d][0]; hi_old[d] = 0; hi_new[d] = 0;
        end
        chg = -1;
        wait_ps("mid", ok);
        if (ok) begin
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge clk);
                if (i == 20) enc_a[0] = 1'b1;
                for (int d = 0; d < ND; d++) hi_old[d] += int'(pwm_all[d][0]);
                if (chg < 0 && val_of(3, 0) != old_v[3]) chg = i;
            end
            @(negedge clk);
            checks++;
            if (ps_all[0] !== 1'b1) begin
                failures++;
                $display("FAIL mid period_len got ps=%b exp 1 after 256 cycles", ps_all[0]);
            end
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge clk);
                for (int d = 0; d < ND; d++) hi_new[d] += int'(pwm_all[d][0]);
            end
            checks++;
            if (!(chg > 20 && chg < 255)) begin
                failures++;
                $display("FAIL mid change_point got %0d exp inside (20,255)", chg);
            end
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (hi_old[d] !== old_v[d] || hi_new[d] !== model_step(old_v[d], 1'b1, d)) begin
                    failures++;
                    $display("FAIL mid glitch_free d%0d got %0d/%0d exp %0d/%0d", d,
                             hi_old[d], hi_new[d], old_v[d], model_step(old_v[d], 1'b1, d));
                end
            end
        end
        enc_a = '0;
        tick_n(HOLD);
        for (int d = 0; d < ND; d++) mv[d][0] = model_step(mv[d][0], 1'b1, d);
        check_vals("mid");
    endtask

    task automatic test_up5();
        for (int k = 0; k < 5; k++) begin
            detent(3'b001, 3'b000);
            check_vals("up5");
        end
        check_pwm("up5");
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            detent(3'b000, 3'b010);
            check_vals("sat_down");
        end
        detent(3'b100, 3'b000);
        check_vals("sat_up");
        check_pwm("sat");
    endtask

    task automatic test_random();
        logic [NC-1:0] up_m, dn_m;
        int r;
        for (int k = 0; k < 12; k++) begin
            up_m = '0; dn_m = '0;
            for (int c = 0; c < NC; c++) begin
                r = $urandom_range(0, 2);
                if (r == 1) up_m[c] = 1'b1;
                if (r == 2) dn_m[c] = 1'b1;
            end
            detent(up_m, dn_m);
            check_vals("random");
        end
        check_pwm("random");
    endtask

    task automatic test_bounce();
        int el, w;
        enc_b = '0;
        tick_n(HOLD);
        el = 0;
        while (el < 2 * DD) begin
            enc_a[2] = ~enc_a[2];
            w = $urandom_range(1, DD / 2);
            tick_n(w);
            el += w;
        end
        enc_a[2] = 1'b1;
        tick_n(HOLD);
        enc_a = '0;
        tick_n(HOLD);
        for (int d = 0; d < ND; d++) mv[d][2] = model_step(mv[d][2], 1'b1, d);
        check_vals("bounce");
    endtask

    task automatic test_reset_mid();
        int n_hi;
        bit ok;
        detent(3'b011, 3'b100);
        check_vals("all_ch");
        wait_ps("rst_mid", ok);
        tick_n(100);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_vals("rst_mid");
        checks++;
        if (pwm_all !== '0 || ps_all !== '0) begin
            failures++;
            $display("FAIL rst_mid outputs got pwm=%h ps=%b exp 0", pwm_all, ps_all);
        end
        enc_b = '0;
        tick_n(4);
        reset_n = 1'b1;
        n_hi = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_hi += int'(pwm_all[0] != '0) + int'(pwm_all[2] != '0);
        end
        checks++;
        if (n_hi !== 0) begin
            failures++;
            $display("FAIL rst_mid no_pulse got %0d high cycles exp 0", n_hi);
        end
        check_vals("rst_release");
        // A level held high through reset must still give exactly one up step.
        reset_n = 1'b0;
        enc_a[1] = 1'b1;
        tick_n(4);
        reset_n = 1'b1;
        model_reset();
        tick_n(3 * HOLD);
        for (int d = 0; d < ND; d++) mv[d][1] = model_step(mv[d][1], 1'b1, d);
        check_vals("held_high");
        enc_a = '0;
        tick_n(HOLD);
        check_vals("held_release");
    endtask

    initial begin
        test_reset();
        test_mid_period();
        test_up5();
        test_saturate();
        test_random();
        test_bounce();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
